cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cp0_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// ============================================================================
// cp0_ctrl -- MIPS-style coprocessor 0 for a five-stage pipeline.
//
// Holds the SR (12), Cause (13) and EPC (14) registers. It raises a single
// exception/interrupt request (Req) combinationally from the M-stage
// instruction and the external interrupt lines. On the next clock edge it
// captures the trap context.
//
// Optional feature:
//   CP0_PRID_EN  -- when defined, address 15 (PRId) reads PRID_VALUE;
//                   otherwise address 15 reads 32'h0.
//
// Parameters:
//   PRID_VALUE   -- constant returned by PRId when it is compiled in.
//
// Ports:
//   clk        in   1   sole clock; every state update happens on posedge
//   reset      in   1   synchronous, active-high; clears SR, Cause and EPC
//   En         in   1   mtc0 write enable (M stage)
//   CP0Addr    in   5   register select for mtc0 and mfc0
//   CP0In      in  32   mtc0 write data
//   CP0Out     out 32   mfc0 read data, combinational from CP0Addr
//   VPC        in  32   PC of the instruction in the M stage
//   BDIn       in   1   M-stage instruction sits in a branch delay slot
//   ExcCodeIn  in   5   M-stage exception code, 0 means no exception
//   HWInt      in   6   external interrupt lines, level-sensitive
//   EXLClr     in   1   eret executing in the M stage
//   EPCOut     out 32   current EPC, used by fetch when eret redirects
//   Req        out  1   trap request: flush the pipeline, jump to 0x4180
// ============================================================================
module cp0_ctrl #(
  parameter logic [31:0] PRID_VALUE = 32'h2023_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // --------------------------------------------------------------------------
  // Architectural state. Only the implemented fields are stored. Every other
  // bit of SR and Cause is tied to zero on read.
  // --------------------------------------------------------------------------
  logic [5:0]  r_im;        // SR.IM  [15:10]
  logic        r_exl;       // SR.EXL [1]
  logic        r_ie;        // SR.IE  [0]
  logic        r_bd;        // Cause.BD [31]
  logic [5:0]  r_ip;        // Cause.IP [15:10]
  logic [4:0]  r_exccode;   // Cause.ExcCode [6:2]
  logic [31:0] r_epc;       // EPC

  logic [5:0]  w_im_next;
  logic        w_exl_next;
  logic        w_ie_next;
  logic        w_bd_next;
  logic [5:0]  w_ip_next;
  logic [4:0]  w_exccode_next;
  logic [31:0] w_epc_next;

  logic [5:0]  w_int_pend;  // per-line: interrupt asserted and unmasked
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_sr_wr;
  logic        w_epc_wr;
  logic [31:0] w_sr_word;
  logic [31:0] w_cause_word;
  logic [31:0] w_prid_word;

  // --------------------------------------------------------------------------
  // Request generation. This path is purely combinational, so the M-stage
  // instruction is flushed in the same cycle in which it is seen. While EXL
  // is set, both interrupt and exception requests are blocked, so traps
  // never nest.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi = gi + 1) begin : g_int_mask
      assign w_int_pend[gi] = HWInt[gi] & r_im[gi];
    end
  endgenerate

  assign w_int_req = (|w_int_pend) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
  assign Req       = w_int_req | w_exc_req;

  // mtc0 decode. An mtc0 issued in the same cycle as a trap is discarded,
  // because that instruction is being flushed.
  assign w_sr_wr  = En & ~Req & (CP0Addr == ADDR_SR);
  assign w_epc_wr = En & ~Req & (CP0Addr == ADDR_EPC);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_im_next      = r_im;
    w_exl_next     = r_exl;
    w_ie_next      = r_ie;
    w_bd_next      = r_bd;
    w_exccode_next = r_exccode;
    w_epc_next     = r_epc;
    // IP tracks the interrupt lines unconditionally, so software always
    // sees the live pending set one cycle late.
    w_ip_next      = HWInt;

    if (Req) begin
      // Trap entry. When an interrupt and an exception occur together, the
      // interrupt wins, and ExcCode records Int (0).
      w_exl_next     = 1'b1;
      w_bd_next      = BDIn;
      w_exccode_next = w_int_req ? 5'd0 : ExcCodeIn;
      // If the instruction is in a delay slot, the return point is the
      // branch before it, so the branch is re-executed.
      w_epc_next     = BDIn ? (VPC - 32'd4) : VPC;
    end else begin
      if (w_sr_wr) begin
        w_im_next  = CP0In[15:10];
        w_exl_next = CP0In[1];
        w_ie_next  = CP0In[0];
      end
      // Apply eret after the SR write, so that an eret leaves EXL cleared
      // even if a concurrent mtc0 SR tries to set EXL.
      if (EXLClr) begin
        w_exl_next = 1'b0;
      end
      if (w_epc_wr) begin
        w_epc_next = CP0In;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers. Reset takes priority over every other update.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_im      <= w_im_next;
      r_exl     <= w_exl_next;
      r_ie      <= w_ie_next;
      r_bd      <= w_bd_next;
      r_ip      <= w_ip_next;
      r_exccode <= w_exccode_next;
      r_epc     <= w_epc_next;
    end
  end

  // --------------------------------------------------------------------------
  // Read side
  // --------------------------------------------------------------------------
  assign w_sr_word    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause_word = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};

`ifdef CP0_PRID_EN
  assign w_prid_word = PRID_VALUE;
`else
  assign w_prid_word = 32'd0;
`endif

  always_comb begin
    CP0Out = 32'd0;
    case (CP0Addr)
      ADDR_SR:    CP0Out = w_sr_word;
      ADDR_CAUSE: CP0Out = w_cause_word;
      ADDR_EPC:   CP0Out = r_epc;
      ADDR_PRID:  CP0Out = w_prid_word;
      default:    CP0Out = 32'd0;
    endcase
  end

  assign EPCOut = r_epc;

  // The mtc0 data bits that have no backing field are deliberately dropped.
  // PRID_VALUE is referenced here as well, so it is consumed in both build
  // variants.
  logic w_unused_bits;
  assign w_unused_bits = ^{CP0In[31:16], CP0In[9:2], PRID_VALUE};

endmodule

// File: tb/tb_cp0_ctrl.sv
// ============================================================================
// tb_cp0_ctrl -- table-driven directed bench for cp0_ctrl.
//
// Each table row applies one cycle of M-stage inputs and checks Req before
// the edge. After the edge, it reads SR, Cause and EPC back through mfc0 and
// also checks EPCOut. Reset, PRId and unimplemented-address reads are
// hand-written sequences.
// ============================================================================
module tb_cp0_ctrl;

  logic        clk;
  logic        reset;
  logic        En;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int n_vec;
  int n_err;

  cp0_ctrl #(.PRID_VALUE(32'h2023_0707)) dut (
    .clk       (clk),
    .reset     (reset),
    .En        (En),
    .CP0Addr   (CP0Addr),
    .CP0In     (CP0In),
    .CP0Out    (CP0Out),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        exlclr;
    logic        exp_req;
    logic [31:0] exp_sr;
    logic [31:0] exp_cause;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic set_vec(input int i, input string name, input logic en, input logic [4:0] addr,
                         input logic [31:0] din, input logic [31:0] vpc, input logic bd,
                         input logic [4:0] exc, input logic [5:0] hw, input logic exlclr,
                         input logic exp_req, input logic [31:0] exp_sr,
                         input logic [31:0] exp_cause, input logic [31:0] exp_epc);
    vecs[i].name = name;       vecs[i].en = en;         vecs[i].addr = addr;
    vecs[i].din = din;         vecs[i].vpc = vpc;       vecs[i].bd = bd;
    vecs[i].exc = exc;         vecs[i].hw = hw;         vecs[i].exlclr = exlclr;
    vecs[i].exp_req = exp_req; vecs[i].exp_sr = exp_sr; vecs[i].exp_cause = exp_cause;
    vecs[i].exp_epc = exp_epc;
  endtask

  task automatic idle_inputs();
    En = 1'b0; CP0Addr = 5'd0; CP0In = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  // Reads SR, Cause and EPC back through mfc0 and checks EPCOut; no clock
  // edge falls inside this window.
  task automatic readback(input string name, input logic [31:0] sr,
                          input logic [31:0] cause, input logic [31:0] epc);
    CP0Addr = 5'd12; #1; check({name, ".SR"}, CP0Out, sr);
    CP0Addr = 5'd13; #1; check({name, ".Cause"}, CP0Out, cause);
    CP0Addr = 5'd14; #1; check({name, ".EPC"}, CP0Out, epc);
    check({name, ".EPCOut"}, EPCOut, epc);
  endtask

  initial begin
    logic [31:0] exp_prid;
    n_vec = 0;
    n_err = 0;
    idle_inputs();

    //            name                en addr  din           vpc           bd exc    hw      clr req SR            Cause         EPC
    set_vec( 0, "mtc0_sr",           1, 5'd12, 32'h0000_0401, 32'h0,        0, 5'd0,  6'h00, 0, 0, 32'h0000_0401, 32'h0000_0000, 32'h0);
    set_vec( 1, "int_req",           0, 5'd0,  32'h0,        32'h0000_1000, 0, 5'd0,  6'h01, 0, 1, 32'h0000_0403, 32'h0000_0400, 32'h0000_1000);
    set_vec( 2, "exl_blocks",        0, 5'd0,  32'h0,        32'h0000_2000, 0, 5'd10, 6'h3F, 0, 0, 32'h0000_0403, 32'h0000_FC00, 32'h0000_1000);
    set_vec( 3, "eret_pending",      0, 5'd0,  32'h0,        32'h0,         0, 5'd0,  6'h01, 1, 0, 32'h0000_0401, 32'h0000_0400, 32'h0000_1000);
    set_vec( 4, "int_after_eret",    0, 5'd0,  32'h0,        32'h0000_1100, 0, 5'd0,  6'h01, 0, 1, 32'h0000_0403, 32'h0000_0400, 32'h0000_1100);
    set_vec( 5, "eret2",             0, 5'd0,  32'h0,        32'h0,         0, 5'd0,  6'h00, 1, 0, 32'h0000_0401, 32'h0000_0000, 32'h0000_1100);
    set_vec( 6, "exc_bd",            0, 5'd0,  32'h0,        32'h0000_3010, 1, 5'd4,  6'h00, 0, 1, 32'h0000_0403, 32'h8000_0010, 32'h0000_300C);
    set_vec( 7, "eret_with_sr_wr",   1, 5'd12, 32'h0000_FC03, 32'h0,        0, 5'd0,  6'h00, 1, 0, 32'h0000_FC01, 32'h8000_0010, 32'h0000_300C);
    set_vec( 8, "epc_wr_vs_exc",     1, 5'd14, 32'h0000_3000, 32'h0000_4000, 0, 5'd12, 6'h00, 0, 1, 32'h0000_FC03, 32'h0000_0030, 32'h0000_4000);
    set_vec( 9, "eret3",             0, 5'd0,  32'h0,        32'h0,         0, 5'd0,  6'h00, 1, 0, 32'h0000_FC01, 32'h0000_0030, 32'h0000_4000);
    set_vec(10, "mtc0_epc",          1, 5'd14, 32'h0000_3000, 32'h0,        0, 5'd0,  6'h00, 0, 0, 32'h0000_FC01, 32'h0000_0030, 32'h0000_3000);
    set_vec(11, "mtc0_cause_ign",    1, 5'd13, 32'hFFFF_FFFF, 32'h0,        0, 5'd0,  6'h00, 0, 0, 32'h0000_FC01, 32'h0000_0030, 32'h0000_3000);
    set_vec(12, "int_beats_exc",     0, 5'd0,  32'h0,        32'h0000_5000, 0, 5'd5,  6'h02, 0, 1, 32'h0000_FC03, 32'h0000_0800, 32'h0000_5000);
    set_vec(13, "eret4",             0, 5'd0,  32'h0,        32'h0,         0, 5'd0,  6'h00, 1, 0, 32'h0000_FC01, 32'h0000_0000, 32'h0000_5000);
    set_vec(14, "req_beats_eret",    0, 5'd0,  32'h0,        32'h0000_6000, 0, 5'd8,  6'h00, 1, 1, 32'h0000_FC03, 32'h0000_0020, 32'h0000_6000);
    set_vec(15, "eret5",             0, 5'd0,  32'h0,        32'h0,         0, 5'd0,  6'h00, 1, 0, 32'h0000_FC01, 32'h0000_0020, 32'h0000_6000);
    set_vec(16, "sr_im_zero",        1, 5'd12, 32'h0000_0001, 32'h0,        0, 5'd0,  6'h00, 0, 0, 32'h0000_0001, 32'h0000_0020, 32'h0000_6000);
    set_vec(17, "im_masks_int",      0, 5'd0,  32'h0,        32'h0000_7000, 0, 5'd0,  6'h3F, 0, 0, 32'h0000_0001, 32'h0000_FC20, 32'h0000_6000);
    set_vec(18, "sr_ie_off",         1, 5'd12, 32'h0000_FC00, 32'h0,        0, 5'd0,  6'h00, 0, 0, 32'h0000_FC00, 32'h0000_0020, 32'h0000_6000);
    set_vec(19, "ie_masks_int",      0, 5'd0,  32'h0,        32'h0000_7000, 0, 5'd0,  6'h3F, 0, 0, 32'h0000_FC00, 32'h0000_FC20, 32'h0000_6000);

    // Reset sequence. A pending mtc0 to EPC must not survive the reset.
    reset = 1'b1;
    En = 1'b1; CP0Addr = 5'd14; CP0In = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset.Req", {31'd0, Req}, 32'd0);
    En = 1'b0;
    readback("reset", 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    idle_inputs();

    // Main table
    for (int i = 0; i < 20; i++) begin
      En = vecs[i].en; CP0Addr = vecs[i].addr; CP0In = vecs[i].din;
      VPC = vecs[i].vpc; BDIn = vecs[i].bd; ExcCodeIn = vecs[i].exc;
      HWInt = vecs[i].hw; EXLClr = vecs[i].exlclr;
      #1;
      check({vecs[i].name, ".Req"}, {31'd0, Req}, {31'd0, vecs[i].exp_req});
      @(posedge clk); #1;
      En = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0;
      readback(vecs[i].name, vecs[i].exp_sr, vecs[i].exp_cause, vecs[i].exp_epc);
    end

    // PRId read and an unimplemented address
`ifdef CP0_PRID_EN
    exp_prid = 32'h2023_0707;
`else
    exp_prid = 32'h0;
`endif
    idle_inputs();
    CP0Addr = 5'd15; #1; check("mfc0_prid", CP0Out, exp_prid);
    CP0Addr = 5'd3;  #1; check("mfc0_unimpl3", CP0Out, 32'h0);
    CP0Addr = 5'd31; #1; check("mfc0_unimpl31", CP0Out, 32'h0);

    // Reset while an exception is pending: reset must win over Req.
    VPC = 32'h0000_9000; ExcCodeIn = 5'd6; HWInt = 6'h3F;
    #1; check("pre_reset.Req", {31'd0, Req}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    ExcCodeIn = 5'd0; HWInt = 6'h00;
    reset = 1'b0;
    @(posedge clk); #1;
    readback("reset_over_req", 32'h0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
